// File: rtl/fifo_reader_pkg.sv
// Shared constants, reader state codes and burst-length helper for the fifo read side.
// No logic of its own; imported by the reader, its next-state block and the bus interface.
// Burst length is clamped to the fifo depth so a burst can never ask for more than 8 words.
package fifo_reader_pkg;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        REQ  = 3'b001,
        WAIT = 3'b010,
        HOLD = 3'b011
    } rd_state_t;

    // Longest burst the fifo can ever satisfy is its depth.
    function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] req_len);
        return (req_len > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : req_len;
    endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// Fifo read port plus downstream valid/ready word stream, seen from reader (master) or peers (slave).
// Pure wiring, no latency.
// out_ready is the only backpressure; the fifo side is ack/err driven.
interface fifo_reader_if;
    import fifo_reader_pkg::*;

    logic              fifo_empty;
    logic              fifo_rd_ack;
    logic              fifo_rd_err;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        input  fifo_empty, fifo_rd_ack, fifo_rd_err, fifo_dout, out_ready,
        output fifo_rd_en, out_data, out_valid
    );

    modport slave (
        output fifo_empty, fifo_rd_ack, fifo_rd_err, fifo_dout, out_ready,
        input  fifo_rd_en, out_data, out_valid
    );
endinterface

// File: rtl/fifo_reader_ns.sv
// Next-state, next-count, done and sticky-error decode for the burst reader.
// Purely combinational; the parent registers every output.
// Waits in HOLD while out_ready is low; abort overrides every other input outside IDLE.
module fifo_reader_ns
    import fifo_reader_pkg::*;
(
    input  rd_state_t        state,
    input  logic [CNT_W-1:0] len,
    input  logic [CNT_W-1:0] rd_count,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             start,
    input  logic             abort,
    input  logic             err,
    input  logic             fifo_empty,
    input  logic             fifo_rd_ack,
    input  logic             fifo_rd_err,
    input  logic             out_ready,
    output rd_state_t        next_state,
    output logic [CNT_W-1:0] next_rd_count,
    output logic             done_d,
    output logic             err_d
);

    logic [CNT_W-1:0] cnt_inc;
    assign cnt_inc = rd_count + 1'b1;

    // Burst sequencing: one read outstanding, word held until the consumer takes it.
    always_comb begin
        next_state    = state;
        next_rd_count = rd_count;
        done_d        = 1'b0;
        err_d         = err;
        if (abort && (state != IDLE)) begin
            // Abort leaves count and error untouched and produces no done.
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        next_rd_count = '0;
                        err_d         = 1'b0;
                        if (burst_len == '0) begin
                            done_d = 1'b1;
                        end else begin
                            next_state = REQ;
                        end
                    end
                end
                REQ: begin
                    if (!fifo_empty) begin
                        next_state = WAIT;
                    end
                end
                WAIT: begin
                    if (fifo_rd_ack) begin
                        next_state = HOLD;
                    end else if (fifo_rd_err) begin
                        err_d      = 1'b1;
                        done_d     = 1'b1;
                        next_state = IDLE;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        next_rd_count = cnt_inc;
                        if (cnt_inc == len) begin
                            done_d     = 1'b1;
                            next_state = IDLE;
                        end else begin
                            next_state = REQ;
                        end
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/fifo_reader.sv
// Burst read master: pulls up to DEPTH words from the fifo and hands each to a valid/ready consumer.
// start -> rd_en 1 cycle, rd_en -> out_valid 2 cycles, at best 3 cycles per word.
// No new read is issued while a word waits for out_ready; an empty fifo stalls without error.
module fifo_reader
    import fifo_reader_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     burst_len,
    input  logic                 abort,
    fifo_reader_if.master        rd_bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CNT_W-1:0]     rd_count
);

    rd_state_t        state;
    rd_state_t        next_state;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] next_rd_count;
    logic             done_d;
    logic             err_d;
    logic             capture;

    fifo_reader_ns u_ns (
        .state         (state),
        .len           (len),
        .rd_count      (rd_count),
        .burst_len     (burst_len),
        .start         (start),
        .abort         (abort),
        .err           (err),
        .fifo_empty    (rd_bus.fifo_empty),
        .fifo_rd_ack   (rd_bus.fifo_rd_ack),
        .fifo_rd_err   (rd_bus.fifo_rd_err),
        .out_ready     (rd_bus.out_ready),
        .next_state    (next_state),
        .next_rd_count (next_rd_count),
        .done_d        (done_d),
        .err_d         (err_d)
    );

    // Read request only from the registered REQ state, so at most one read is ever in flight.
    assign rd_bus.fifo_rd_en = (state == REQ) && !rd_bus.fifo_empty;
    assign busy              = (state != IDLE);
    // A word arriving together with abort is dropped.
    assign capture           = (state == WAIT) && rd_bus.fifo_rd_ack && !abort;

    // Control registers: state, latched burst length, count, done pulse, sticky error.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            len       <= '0;
            rd_count  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state    <= next_state;
            rd_count <= next_rd_count;
            done     <= done_d;
            err      <= err_d;
            if ((state == IDLE) && start && (burst_len != '0)) begin
                len <= clamp_len(burst_len);
            end
        end
    end

    // Output word register: valid exactly while in HOLD, data frozen until accepted.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_bus.out_valid <= 1'b0;
            rd_bus.out_data  <= '0;
        end else begin
            rd_bus.out_valid <= (next_state == HOLD);
            if (capture) begin
                rd_bus.out_data <= rd_bus.fifo_dout;
            end
        end
    end

endmodule
